// File: rtl/fp32_divider_seq.sv
// fp32_divider_seq: sequential IEEE-754 single-precision divider, result = a / b.
// Restoring mantissa division (one quotient bit per cycle), round-to-nearest-even,
// subnormal inputs flushed to zero, valid/ready handshake on both sides.
// Optional macro FP_DIV_IEEE_NAN_EN: IEEE-style NaN/infinity/zero results for
// exceptional operands instead of the multiplier-compatible all-zero result.
module fp32_divider_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow,
    output logic        DivByZero
);
    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;     // ea - eb + 127, assuming quotient in [1,2)
    logic [23:0]        mb_q, mb_d;
    logic [24:0]        r_q, r_d;
    logic [25:0]        quo_q, quo_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        result_q, result_d;
    logic               exc_q, exc_d, ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d;

    logic [7:0]         ea, eb;
    logic               in_sign;
    logic               sp_exc;
    logic [31:0]        sp_res;

    assign ea      = a_operand[30:23];
    assign eb      = b_operand[30:23];
    assign in_sign = a_operand[31] ^ b_operand[31];

    // Classify exceptional operands (exponent all ones, plus 0/0 in IEEE mode)
`ifdef FP_DIV_IEEE_NAN_EN
    logic a_nan, b_nan, a_inf, b_inf;
    always_comb begin
        a_nan  = (ea == 8'hFF) && (a_operand[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b_operand[22:0] != 23'd0);
        a_inf  = (ea == 8'hFF) && (a_operand[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b_operand[22:0] == 23'd0);
        sp_exc = 1'b0;
        sp_res = 32'd0;
        if (a_nan || b_nan || (a_inf && b_inf) || (ea == 8'd0 && eb == 8'd0)) begin
            sp_exc = 1'b1;
            sp_res = 32'h7FC0_0000;
        end else if (a_inf) begin
            sp_exc = 1'b1;
            sp_res = {in_sign, 8'hFF, 23'd0};
        end else if (b_inf) begin
            sp_exc = 1'b1;
            sp_res = {in_sign, 31'd0};
        end
    end
`else
    always_comb begin
        sp_exc = (ea == 8'hFF) || (eb == 8'hFF);
        sp_res = 32'd0;
    end
`endif

    logic [22:0]        mant;
    logic               g, s;
    logic [23:0]        mant_rnd;
    logic signed [9:0]  exp_n, exp_r;
    logic               rnd_ovf, rnd_unf;
    logic [31:0]        rnd_res;

    // Normalise the quotient, round to nearest even, then range-check the exponent
    always_comb begin
        if (quo_q[25]) begin
            mant  = quo_q[24:2];
            g     = quo_q[1];
            s     = quo_q[0] | (|r_q);
            exp_n = exp_q;
        end else begin
            mant  = quo_q[23:1];
            g     = quo_q[0];
            s     = |r_q;
            exp_n = exp_q - 10'sd1;
        end
        mant_rnd = {1'b0, mant} + {23'd0, g & (s | mant[0])};
        exp_r    = mant_rnd[23] ? exp_n + 10'sd1 : exp_n;   // carry-out leaves mant_rnd[22:0] == 0
        rnd_ovf  = (exp_r >= 10'sd255);
        rnd_unf  = (exp_r <= 10'sd0);
        if (rnd_ovf)      rnd_res = {sign_q, 8'hFF, 23'd0};
        else if (rnd_unf) rnd_res = {sign_q, 31'd0};
        else              rnd_res = {sign_q, exp_r[7:0], mant_rnd[22:0]};
    end

    // Control FSM and datapath next-state
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mb_d     = mb_q;
        r_d      = r_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    exc_d  = 1'b0;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    dbz_d  = 1'b0;
                    if (sp_exc) begin
                        exc_d    = 1'b1;
                        result_d = sp_res;
                        state_d  = DONE;
                    end else if (eb == 8'd0) begin
                        dbz_d    = 1'b1;
                        result_d = {in_sign, 8'hFF, 23'd0};
                        state_d  = DONE;
                    end else if (ea == 8'd0) begin
                        result_d = {in_sign, 31'd0};
                        state_d  = DONE;
                    end else begin
                        exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
                        r_d     = {2'b01, a_operand[22:0]};
                        mb_d    = {1'b1, b_operand[22:0]};
                        quo_d   = 26'd0;
                        cnt_d   = 5'd25;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                // Quotient bits shift in from the LSB; the first bit lands in quo[25]
                if (r_q >= {1'b0, mb_q}) begin
                    quo_d = {quo_q[24:0], 1'b1};
                    r_d   = (r_q - {1'b0, mb_q}) << 1;
                end else begin
                    quo_d = {quo_q[24:0], 1'b0};
                    r_d   = r_q << 1;
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = ROUND;
            end
            ROUND: begin
                result_d = rnd_res;
                ovf_d    = rnd_ovf;
                unf_d    = rnd_unf & ~rnd_ovf;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    exc_d   = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    dbz_d   = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= 10'sd0;
            mb_q     <= 24'd0;
            r_q      <= 25'd0;
            quo_q    <= 26'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mb_q     <= mb_d;
            r_q      <= r_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign Exception = exc_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign DivByZero = dbz_q;
endmodule

// File: tb/tb_fp32_divider_seq.sv
// Self-checking bench for fp32_divider_seq: directed vectors, backpressure,
// reset abort and randomized operands against a long-division reference model.
module tb_fp32_divider_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_operand, b_operand;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        Exception, Overflow, Underflow, DivByZero;

    fp32_divider_seq dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_operand(a_operand), .b_operand(b_operand),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .Exception(Exception), .Overflow(Overflow),
        .Underflow(Underflow), .DivByZero(DivByZero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        exc, ovf, unf, dbz;
        logic        normal;
    } exp_t;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    exp_t q_exp[$];
    int   q_acc[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    endtask

    // Reference: exact integer quotient of the significands, then RNE to 24 bits
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int ea, eb, ex;
        longint ma, mb, num, q, rem, sig, mask;
        logic g, st, s;
        e  = '0;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
`ifdef FP_DIV_IEEE_NAN_EN
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
            (ea == 255 && eb == 255) || (ea == 0 && eb == 0)) begin
            e.exc = 1'b1; e.res = 32'h7FC0_0000; return e;
        end
        if (ea == 255) begin e.exc = 1'b1; e.res = {s, 8'hFF, 23'd0}; return e; end
        if (eb == 255) begin e.exc = 1'b1; e.res = {s, 31'd0}; return e; end
`else
        if (ea == 255 || eb == 255) begin e.exc = 1'b1; e.res = 32'd0; return e; end
`endif
        if (eb == 0) begin e.dbz = 1'b1; e.res = {s, 8'hFF, 23'd0}; return e; end
        if (ea == 0) begin e.res = {s, 31'd0}; return e; end
        e.normal = 1'b1;
        ma  = longint'({1'b1, a[22:0]});
        mb  = longint'({1'b1, b[22:0]});
        num = ma << 38;
        q   = num / mb;
        rem = num % mb;
        if (q >= (64'sd1 << 38)) begin
            sig  = q >> 15;
            g    = q[14];
            mask = (64'sd1 << 14) - 1;
            ex   = ea - eb + 127;
        end else begin
            sig  = q >> 14;
            g    = q[13];
            mask = (64'sd1 << 13) - 1;
            ex   = ea - eb + 126;
        end
        st = ((q & mask) != 0) || (rem != 0);
        if (g && (st || sig[0])) sig = sig + 1;
        if (sig == (64'sd1 << 24)) begin sig = 64'sd1 << 23; ex = ex + 1; end
        if (ex >= 255)    begin e.ovf = 1'b1; e.res = {s, 8'hFF, 23'd0}; end
        else if (ex <= 0) begin e.unf = 1'b1; e.res = {s, 31'd0}; end
        else              e.res = {s, ex[7:0], sig[22:0]};
        return e;
    endfunction

    task automatic pin(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [3:0] flags);
        exp_t e;
        e = model(a, b);
        chk(name, {e.res, e.exc, e.ovf, e.unf, e.dbz}, {res, flags});
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process: checks every cycle out_valid is high, tracks accepts
    initial forever begin
        exp_t e;
        logic head_seen;
        head_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                q_exp.delete();
                q_acc.delete();
                head_seen = 1'b0;
            end else begin
                if (out_valid) begin
                    if (q_exp.size() == 0) begin
                        chk("spurious_out_valid", {31'd0, out_valid}, 0);
                    end else begin
                        e = q_exp[0];
                        if (!head_seen) begin
                            chk("latency", cyc - q_acc[0], e.normal ? 27 : 0);
                            head_seen = 1'b1;
                        end
                        chk("result", result, e.res);
                        chk("flags", {Exception, Overflow, Underflow, DivByZero},
                            {e.exc, e.ovf, e.unf, e.dbz});
                        chk("in_ready_busy", {31'd0, in_ready}, 0);
                        if (out_ready) begin
                            void'(q_exp.pop_front());
                            void'(q_acc.pop_front());
                            head_seen = 1'b0;
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    q_exp.push_back(model(a_operand, b_operand));
                    q_acc.push_back(cyc + 1);
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        in_valid  = 1'b1;
        a_operand = a;
        b_operand = b;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("accept_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("idle_reached", {31'd0, in_ready}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] va[10];
        logic [31:0] vb[10];
        int nv;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_operand = 32'd0; b_operand = 32'd0;

        // Hand-computed expectations that pin the reference model
        pin("pin_6div2",   32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000);
        pin("pin_1div3",   32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000);
        pin("pin_1div1",   32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000);
        pin("pin_1div0",   32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0001);
`ifdef FP_DIV_IEEE_NAN_EN
        pin("pin_infdiv1", 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 4'b1000);
`else
        pin("pin_infdiv1", 32'h7F80_0000, 32'h3F80_0000, 32'h0000_0000, 4'b1000);
`endif
        pin("pin_ovf",     32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 4'b0100);
        pin("pin_unf",     32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 4'b0010);
        pin("pin_zero",    32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 4'b0000);
        pin("pin_neg",     32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 4'b0000);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_result", result, 0);
        chk("rst_flags", {Exception, Overflow, Underflow, DivByZero}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);

        // Directed vectors, back to back
        va = '{32'h40C0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000,
               32'h7F00_0000, 32'h0080_0000, 32'h0000_0000, 32'hC0C0_0000, 32'h0000_0000};
        vb = '{32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000,
               32'h0080_0000, 32'h7F00_0000, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0000};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(va[i], vb[i]);
        wait_idle();

        // Backpressure: result held, new operands ignored
        out_ready = 1'b0;
        send(32'h40C0_0000, 32'h4000_0000);
        nv = 0;
        while (!out_valid && nv < 40) begin @(posedge clk); #1; nv++; end
        chk("bp_out_valid", {31'd0, out_valid}, 1);
        in_valid = 1'b1; a_operand = 32'h3F80_0000; b_operand = 32'h4040_0000;
        repeat (5) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released_valid", {31'd0, out_valid}, 0);
        chk("bp_released_ready", {31'd0, in_ready}, 1);
        chk("bp_result_kept", result, 32'h4040_0000);
        chk("bp_flags_cleared", {Exception, Overflow, Underflow, DivByZero}, 0);

        // Reset during DIV aborts the operation
        send(32'h3F80_0000, 32'h4040_0000);
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_in_ready", {31'd0, in_ready}, 1);
        chk("abort_out_valid", {31'd0, out_valid}, 0);
        nv = 0;
        repeat (35) begin @(posedge clk); #1; if (out_valid) nv++; end
        chk("abort_no_stale", nv, 0);

        // Random normal-range operands, then fully random bit patterns
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
            send(ra, rb);
        end
        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra, rb;
            ra = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            send(ra, rb);
        end
        for (int i = 0; i < 20; i++) send($urandom, $urandom);
        wait_idle();
        @(posedge clk); #1;
        chk("drained", q_exp.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fp32_divider_seq.md
Name: fp32_divider_seq

Overview:
- Sequential IEEE-754 single-precision divider: result = a_operand / b_operand.
- Companion to the team's combinational FP32 multiplier. Uses the same operand format and the same Exception/Overflow/Underflow flag semantics.
- Feeds the fuzzy-inference defuzzification stage (centroid = weighted sum / sum of weights).
- Iterative restoring divider, one quotient bit per cycle, valid/ready handshake on both sides.

Parameters:
- none (fixed FP32 format: 1 sign, 8 exponent bits, bias 127, 23 fraction bits)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  operands valid
- in_ready  output  1  block idle, can accept operands
- a_operand  input  32  dividend
- b_operand  input  32  divisor
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- result  output  32  quotient
- Exception  output  1  either operand exponent == 8'hFF
- Overflow  output  1  biased exponent >= 255 after rounding
- Underflow  output  1  biased exponent <= 0 after rounding
- DivByZero  output  1  divisor is zero and Exception == 0

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; result=0; all flags=0. Reset mid-operation aborts the division and discards the operands.
- States: IDLE, DIV, ROUND, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, register operands, sign=a[31]^b[31], then classify:
  - Exception case → DONE, result=32'd0.
  - Else b exponent==0 → DONE, DivByZero=1, result={sign,8'hFF,23'd0}.
  - Else a exponent==0 → DONE, result={sign,31'd0}.
  - Else → DIV.
  - Special cases: out_valid asserts on the cycle after the accepting edge.
- Subnormal inputs (exponent 0) are flushed to zero. The hidden bit is always 1 for operands that reach DIV.
- DIV:
  - ma={1,a[22:0]}, mb={1,b[22:0]}; 25-bit remainder r, initialised to ma; 5-bit counter runs 25 down to 0.
  - Each cycle: if r>=mb then q[i]=1 and r=r-mb, else q[i]=0; then r=r<<1.
  - 26 cycles total, then → ROUND.
- ROUND (1 cycle):
  - If q[25]=1: mant=q[24:2], g=q[1], s=q[0]|(r!=0), exp=ea-eb+127.
  - Else: mant=q[23:1], g=q[0], s=(r!=0), exp=ea-eb+126.
  - Exponent is held in 10-bit signed arithmetic.
  - Round to nearest even: add g&(s|mant[0]). On mantissa carry-out, mant=0 and exp=exp+1.
  - exp>=255 → Overflow=1, result={sign,8'hFF,23'd0}.
  - exp<=0 → Underflow=1, result={sign,31'd0}.
  - Otherwise result={sign,exp[7:0],mant}.
  - Next state → DONE.
- DONE: out_valid=1; in_ready=0. result and flags are registered and held stable while out_ready=0. On out_valid && out_ready: out_valid=0, flags cleared, → IDLE. result keeps its last value.
- Normal-path latency: out_valid rises on the 27th rising edge after the accepting edge (26 DIV + 1 ROUND), independent of the operand values.
- Throughput: one operation in flight. in_ready=0 in DIV, ROUND and DONE, so no new operands are accepted until the result handshake completes.
- Flag priority: Exception > DivByZero > zero dividend > Overflow > Underflow. At most one flag is high per result.

Optional Feature:
- Macro: FP_DIV_IEEE_NAN_EN.
- Defined:
  - Exception case with NaN operand (exp=FF, frac!=0), inf/inf, or 0/0 → result=32'h7FC00000, Exception=1.
  - inf/finite → {sign,8'hFF,23'd0}, Exception=1.
  - finite/inf → {sign,31'd0}, Exception=1.
- Undefined: every Exception case outputs 32'd0, and 0/0 reports DivByZero, matching the multiplier.

Test Plan:
- 6.0/2.0 (a=0x40C00000, b=0x40000000) → result 0x40400000, all flags 0, out_valid 27 edges after accept.
- 1.0/3.0 (0x3F800000/0x40400000) → 0x3EAAAAAB (round-up via sticky); 1.0/1.0 → 0x3F800000.
- 1.0/0.0 → 0x7F800000, DivByZero=1, out_valid 1 edge after accept. 0x7F800000/0x3F800000 → 0x00000000, Exception=1 (0x7F800000 with FP_DIV_IEEE_NAN_EN).
- 0x7F000000/0x00800000 → 0x7F800000, Overflow=1. 0x00800000/0x7F000000 → 0x00000000, Underflow=1. 0x00000000/0x3F800000 → 0x00000000, no flags.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → result/flags stable, in_ready=0, a new in_valid is ignored. Release → one transfer, then in_ready=1 on the following cycle.
- Assert reset during DIV (cycle 10) → next cycle in_ready=1, out_valid=0, no stale result emitted. Back-to-back random normal operands vs a reference model, including negatives (-6.0/2.0 → 0xC0400000).
